// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// reset-cause codes, event counter width and a saturating increment helper.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  localparam int COUNT_W = 8;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/reset_sequencer_rst_req_filter.sv
// External reset request conditioner: two-flop synchroniser followed by a
// consecutive-sample filter. ext_filt rises on the REQ_FILT-th consecutive
// high synchronised sample and drops on the first low one.
module rst_req_filter #(
  parameter int REQ_FILT = 4
) (
  input  logic clk_25,
  input  logic reset,
  input  logic ext_rst_req,
  output logic ext_filt
);

  localparam int FC_W = $clog2(REQ_FILT + 1);
  localparam logic [FC_W-1:0] FILT_MAX  = FC_W'(REQ_FILT);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(REQ_FILT - 1);

  logic            sync1;
  logic            sync2;
  logic [FC_W-1:0] run_cnt;

  // Bring the asynchronous pin into the clk_25 domain.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ext_rst_req;
      sync2 <= sync1;
    end
  end

  // Count consecutive high samples; a single low sample clears everything.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      run_cnt  <= '0;
      ext_filt <= 1'b0;
    end else if (!sync2) begin
      run_cnt  <= '0;
      ext_filt <= 1'b0;
    end else begin
      if (run_cnt != FILT_MAX)
        run_cnt <= run_cnt + FC_W'(1);
      ext_filt <= (run_cnt >= FILT_LAST);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator. Holds all channels in reset for POR_DELAY cycles
// after reset or an accepted request, then releases ch0..ch(NUM_CH-1) one
// STAGE_DELAY apart. Records the last reset cause and counts request events.
// The countdown is "expire when the counter reads 1" so that a load of N
// releases on exactly the N-th edge after the load.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int POR_DELAY   = 250,
  parameter int STAGE_DELAY = 25,
  parameter int REQ_FILT    = 4
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic               ext_rst_req,
  input  logic               sw_rst_req,
  output logic [NUM_CH-1:0]  rst_out,
  output logic               seq_busy,
  output logic               all_released,
  output logic [1:0]         rst_cause,
  output logic [COUNT_W-1:0] rst_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] POR_LOAD   = CNT_W'(POR_DELAY);
  localparam logic [CNT_W-1:0] STAGE_LOAD = CNT_W'(STAGE_DELAY);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

  seq_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [NUM_CH-1:0] rst_out_nx;
  logic              ext_filt;
  logic              ext_filt_d;
  logic              req;
  logic              ext_event;
  logic              cnt_expired;

  rst_req_filter #(
    .REQ_FILT (REQ_FILT)
  ) u_filter (
    .clk_25      (clk_25),
    .reset       (reset),
    .ext_rst_req (ext_rst_req),
    .ext_filt    (ext_filt)
  );

  // A held ext_filt keeps reloading the sequence but only its rising edge is an event.
  assign req         = sw_rst_req | ext_filt;
  assign ext_event   = ext_filt & ~ext_filt_d;
  assign cnt_expired = (cnt <= CNT_W'(1));

  // State, counter, index and registered outputs.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state        <= ST_HOLD;
      cnt          <= POR_LOAD;
      idx          <= '0;
      rst_out      <= '1;
      seq_busy     <= 1'b1;
      all_released <= 1'b0;
      ext_filt_d   <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      rst_out      <= rst_out_nx;
      seq_busy     <= (state_nx != ST_RUN);
      all_released <= (state_nx == ST_RUN);
      ext_filt_d   <= ext_filt;
    end
  end

  // Next state: any request restarts HOLD, otherwise count down and step through channels.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (req) begin
      state_nx = ST_HOLD;
      cnt_nx   = POR_LOAD;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt_expired) begin
            cnt_nx   = STAGE_LOAD;
            idx_nx   = IDX_W'(1);
            state_nx = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_expired) begin
            cnt_nx = STAGE_LOAD;
            if (idx == LAST_IDX) begin
              state_nx = ST_RUN;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + IDX_W'(1);
            end
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_nx = ST_RUN;
        end
        default: begin
          state_nx = ST_HOLD;
          cnt_nx   = POR_LOAD;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Next reset mask: channels only ever clear one at a time, lowest first.
  always_comb begin
    rst_out_nx = rst_out;
    if (req) begin
      rst_out_nx = '1;
    end else begin
      case (state)
        ST_HOLD:    rst_out_nx = cnt_expired ? ~NUM_CH'(1) : '1;
        ST_RELEASE: if (cnt_expired) rst_out_nx = rst_out & ~(NUM_CH'(1) << idx);
        ST_RUN:     rst_out_nx = '0;
        default:    rst_out_nx = '1;
      endcase
    end
  end

  // Cause and event count; an external event wins over a same-cycle software request.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      rst_cause <= CAUSE_POR;
      rst_count <= '0;
    end else if (ext_event) begin
      rst_cause <= CAUSE_EXT;
      rst_count <= sat_inc(rst_count);
    end else if (sw_rst_req) begin
      rst_cause <= CAUSE_SW;
      rst_count <= sat_inc(rst_count);
    end
  end

endmodule
